// File: rtl/psram_opi_resp.sv
// psram_opi_resp: device side of an octal DDR PSRAM link.
// SCK, CE and IO are oversampled by clk_i through 2-flop synchronizers. An
// FSM walks the opcode, address, latency and data phases; write bytes go
// into a byte array and read bytes come back out of it with a DQS strobe.
// Optional feature macro: PSRAM_RESP_DM_EN (DQS acts as a write data mask).
`timescale 1ns/1ps

module psram_opi_resp #(
  parameter int unsigned DEPTH  = 1024,
  parameter logic [7:0]  RD_CMD = 8'h00,
  parameter logic [7:0]  WR_CMD = 8'h80,
  parameter int unsigned RLC    = 5,
  parameter int unsigned WLC    = 5,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          psram_sck_i,
  input  logic          psram_ce_i,
  input  logic [7:0]    psram_io_in_i,
  output logic [7:0]    psram_io_out_o,
  output logic [7:0]    psram_io_en_o,
  input  logic          psram_dqs_in_i,
  output logic          psram_dqs_out_o,
  output logic          psram_dqs_en_o,
  input  logic [AW-1:0] bd_addr_i,
  output logic [7:0]    bd_data_o,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INST,
    ST_ADDR,
    ST_LATN,
    ST_RDATA,
    ST_WDATA,
    ST_IGNR
  } state_e;

  // Synchronizer stages (_m = metastable stage, _s = synchronized, _p = previous)
  logic       sck_m_q, sck_s_q, sck_p_q;
  logic       ce_m_q, ce_s_q, ce_p_q;
  logic [7:0] io_m_q, io_s_q;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    io_out_q, io_out_d;
  logic          dqs_out_q, dqs_out_d;
  logic          err_q, err_d;
  logic          mem_we;
  logic          mask;

  logic [7:0] mem [DEPTH];

  logic sck_rise, sck_fall, sck_edge, ce_rise, ce_fall;

  // Bring the asynchronous pins into the clk_i domain, all with equal delay
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_m_q <= 1'b0;
      sck_s_q <= 1'b0;
      sck_p_q <= 1'b0;
      ce_m_q  <= 1'b0;
      ce_s_q  <= 1'b0;
      ce_p_q  <= 1'b0;
      io_m_q  <= 8'h00;
      io_s_q  <= 8'h00;
    end else begin
      sck_m_q <= psram_sck_i;
      sck_s_q <= sck_m_q;
      sck_p_q <= sck_s_q;
      ce_m_q  <= psram_ce_i;
      ce_s_q  <= ce_m_q;
      ce_p_q  <= ce_s_q;
      io_m_q  <= psram_io_in_i;
      io_s_q  <= io_m_q;
    end
  end

`ifdef PSRAM_RESP_DM_EN
  logic dqs_m_q, dqs_s_q;

  // Synchronize the write mask alongside the other pins
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dqs_m_q <= 1'b0;
      dqs_s_q <= 1'b0;
    end else begin
      dqs_m_q <= psram_dqs_in_i;
      dqs_s_q <= dqs_m_q;
    end
  end

  assign mask = dqs_s_q;
`else
  logic unused_dqs_in;
  assign unused_dqs_in = psram_dqs_in_i;
  assign mask          = 1'b0;
`endif

  assign sck_rise = sck_s_q & ~sck_p_q;
  assign sck_fall = ~sck_s_q & sck_p_q;
  assign sck_edge = sck_rise | sck_fall;
  assign ce_rise  = ce_s_q & ~ce_p_q;
  assign ce_fall  = ~ce_s_q & ce_p_q;

  // Phase decoding: next state, address/counter updates, read data and write strobe
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    io_out_d  = io_out_q;
    dqs_out_d = dqs_out_q;
    err_d     = err_q;
    mem_we    = 1'b0;

    if (ce_rise) begin
      // CE rising ends any burst and overrides a coincident SCK edge.
      state_d = ST_IDLE;
      if (state_q == ST_INST || state_q == ST_ADDR) err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ce_fall) state_d = ST_INST;
        end
        ST_INST: begin
          if (sck_rise) begin
            if (io_s_q == RD_CMD || io_s_q == WR_CMD) begin
              is_wr_d = (io_s_q == WR_CMD);
              cnt_d   = 8'd0;
              state_d = ST_ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IGNR;
            end
          end
        end
        ST_ADDR: begin
          // Edge 0 is the opcode's fall byte and is skipped; edges 1..4 carry
          // the address MSB first.
          if (sck_edge) begin
            if (cnt_q == 8'd0) begin
              cnt_d = 8'd1;
            end else begin
              addr_d = AW'({addr_q, io_s_q});
              cnt_d  = cnt_q + 8'd1;
              if (cnt_q == 8'd4) begin
                addr_d[0] = 1'b0;
                cnt_d     = is_wr_q ? 8'(WLC) : 8'(RLC);
                state_d   = ST_LATN;
              end
            end
          end
        end
        ST_LATN: begin
          if (sck_rise) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = is_wr_q ? ST_WDATA : ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (sck_edge) begin
            mem_we = ~mask;
            addr_d = addr_q + AW'(1);
          end
        end
        ST_RDATA: begin
          if (sck_edge) begin
            io_out_d  = mem[addr_q];
            dqs_out_d = sck_s_q;
            addr_d    = addr_q + AW'(1);
          end
        end
        ST_IGNR: begin
          state_d = ST_IGNR;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      io_out_q  <= 8'h00;
      dqs_out_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      io_out_q  <= io_out_d;
      dqs_out_q <= dqs_out_d;
      err_q     <= err_d;
    end
  end

  // Byte array write port
  // NOTE: the array is deliberately not reset so it can map onto RAM; contents survive rst_n_i.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[addr_q] <= io_s_q;
  end

  assign bd_data_o       = mem[bd_addr_i];
  assign psram_io_out_o  = io_out_q;
  assign psram_dqs_out_o = dqs_out_q;
  assign psram_io_en_o   = {8{state_q == ST_RDATA}};
  assign psram_dqs_en_o  = (state_q == ST_RDATA);
  assign busy_o          = (state_q != ST_IDLE);
  assign err_o           = err_q;

endmodule

// File: tb/tb_psram_opi_resp.sv
// tb_psram_opi_resp: directed bench for psram_opi_resp. A byte-array model
// tracks what the device must hold; a compare process checks output enables,
// busy and read data every cycle against expectations derived from pin timing.
`timescale 1ns/1ps

module tb_psram_opi_resp;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [7:0]  RD_CMD = 8'h00;
  localparam logic [7:0]  WR_CMD = 8'h80;
  localparam int          RLC    = 5;
  localparam int          WLC    = 5;
  localparam time         CLK_P  = 10;
  localparam time         LAT    = 3 * CLK_P;  // pin change to visible output

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psram_sck, psram_ce, psram_dqs;
  logic [7:0]    psram_io;
  logic [7:0]    io_out, io_en;
  logic          dqs_out, dqs_en;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;
  logic          busy, err;

  psram_opi_resp #(
    .DEPTH(DEPTH), .RD_CMD(RD_CMD), .WR_CMD(WR_CMD), .RLC(RLC), .WLC(WLC)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .psram_sck_i    (psram_sck),
    .psram_ce_i     (psram_ce),
    .psram_io_in_i  (psram_io),
    .psram_io_out_o (io_out),
    .psram_io_en_o  (io_en),
    .psram_dqs_in_i (psram_dqs),
    .psram_dqs_out_o(dqs_out),
    .psram_dqs_en_o (dqs_en),
    .bd_addr_i      (bd_addr),
    .bd_data_o      (bd_data),
    .busy_o         (busy),
    .err_o          (err)
  );

  always #(CLK_P / 2) clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  typedef struct { time t; bit kind; bit v; } ev_t;             // kind 0: output enable, 1: busy
  typedef struct { time t; logic [7:0] d; bit s; bit known; } rd_t;

  logic [7:0] mem_model [DEPTH];
  bit         mem_known [DEPTH];
  ev_t        ev_q[$];
  rd_t        rq[$];
  bit         exp_oe, exp_busy, chk_en;
  logic [7:0] wd [8];
  bit         wm [8];
  int         n_checks = 0;
  int         n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input time t, input bit kind, input bit v);
    ev_q.push_back('{t + LAT, kind, v});
  endtask

  task automatic flush();
    ev_q.delete();
    rq.delete();
    exp_oe   = 1'b0;
    exp_busy = 1'b0;
  endtask

  // One SCK phase: toggle SCK with data/mask, hold for two clk cycles (div4).
  task automatic sck_edge(input logic [7:0] d, input logic m);
    psram_sck = ~psram_sck;
    psram_io  = d;
    psram_dqs = m;
    wait_clk(2);
  endtask

  // Raise CE; if SCK is high, drop it in the same instant with a junk byte
  // that must be discarded.
  task automatic ce_rise();
    psram_ce = 1'b1;
    if (psram_sck) begin
      psram_sck = 1'b0;
      psram_io  = 8'hEE;
    end
    push_ev($time, 1'b0, 1'b0);
    push_ev($time, 1'b1, 1'b0);
    wait_clk(4);
  endtask

  task automatic bd_check(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    bd_addr = a;
    #1;
    check(name, 32'(bd_data), 32'(exp));
  endtask

  task automatic set_wd(input logic [31:0] w, input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      wd[i] = w[31-8*i -: 8];
      wm[i] = m[3-i];
    end
    for (int i = 4; i < 8; i++) begin
      wd[i] = 8'h00;
      wm[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    wait_clk(1);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    flush();
    wait_clk(6);
    chk_en = 1'b1;
  endtask

  task automatic reset_mid();
    check("pre_rst_io_en", 32'(io_en), 32'hFF);
    check("pre_rst_dqs_out", 32'(dqs_out), 32'd1);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst_io_en", 32'(io_en), 32'h0);
    check("rst_dqs_en", 32'(dqs_en), 32'h0);
    check("rst_dqs_out", 32'(dqs_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    flush();
    psram_ce  = 1'b1;
    psram_sck = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    chk_en = 1'b1;
  endtask

  // Full controller-side burst. abort_at: address byte index at which CE
  // rises (4 = never); rst_at: data index at which reset hits (-1 = never).
  task automatic burst(input logic [7:0] op, input logic [31:0] a, input int n,
                       input int abort_at, input int rst_at);
    logic [AW-1:0] ptr;
    time           t;
    int            lat;
    bit            is_rd, is_wr;
    is_rd = (op == RD_CMD);
    is_wr = (op == WR_CMD);
    lat   = is_rd ? RLC : WLC;
    t     = 0;
    wait_clk(1);
    psram_ce = 1'b0;
    push_ev($time, 1'b1, 1'b1);
    wait_clk(2);
    sck_edge(op, 1'b0);
    sck_edge(~op, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == abort_at) begin
        ce_rise();
        return;
      end
      sck_edge(a[31-8*i -: 8], 1'b0);
    end
    // lat rises with falls between them; data starts on the following fall
    for (int i = 0; i < 2 * lat - 1; i++) begin
      t = $time;
      sck_edge(8'h00, 1'b0);
    end
    if (is_rd) push_ev(t, 1'b0, 1'b1);
    ptr = a[AW-1:0] & ~AW'(1);
    for (int j = 0; j < n; j++) begin
      if (j == rst_at) begin
        reset_mid();
        return;
      end
      if (is_rd) rq.push_back('{$time + LAT, mem_model[ptr], ~psram_sck, mem_known[ptr]});
      sck_edge(wd[j], is_rd ? 1'b0 : wm[j]);
      if (is_wr) begin
`ifdef PSRAM_RESP_DM_EN
        if (!wm[j]) begin
          mem_model[ptr] = wd[j];
          mem_known[ptr] = 1'b1;
        end
`else
        mem_model[ptr] = wd[j];
        mem_known[ptr] = 1'b1;
`endif
      end
      ptr = ptr + AW'(1);
    end
    ce_rise();
  endtask

  // ---------------- compare process ----------------
  // Applies due expectation events, then checks enables, busy and read data.
  always @(negedge clk) begin
    ev_t e;
    rd_t r;
    if (chk_en) begin
      while (ev_q.size() > 0 && ev_q[0].t <= $time) begin
        e = ev_q.pop_front();
        if (e.kind) exp_busy = e.v;
        else        exp_oe   = e.v;
      end
      check("io_en", 32'(io_en), {24'd0, {8{exp_oe}}});
      check("dqs_en", 32'(dqs_en), 32'(exp_oe));
      check("busy", 32'(busy), 32'(exp_busy));
      if (rq.size() > 0 && rq[0].t <= $time) begin
        r = rq.pop_front();
        if (r.known) check("rd_data", 32'(io_out), 32'(r.d));
        check("rd_dqs", 32'(dqs_out), 32'(r.s));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_known[i] = 1'b0;
    chk_en    = 1'b0;
    exp_oe    = 1'b0;
    exp_busy  = 1'b0;
    rst_n     = 1'b0;
    psram_ce  = 1'b1;
    psram_sck = 1'b0;
    psram_io  = 8'h00;
    psram_dqs = 1'b0;
    bd_addr   = '0;
    set_wd(32'h0, 4'h0);
    wait_clk(3);
    #1;
    check("reset_io_en", 32'(io_en), 32'h0);
    check("reset_dqs_en", 32'(dqs_en), 32'h0);
    check("reset_dqs_out", 32'(dqs_out), 32'h0);
    check("reset_io_out", 32'(io_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    wait_clk(6);
    chk_en = 1'b1;

    // Basic write, preceded by a guard write at 0x14 for the CE-wins edge.
    set_wd(32'h5A6B0000, 4'h0);
    burst(WR_CMD, 32'h0000_0014, 2, 4, -1);
    set_wd(32'hA1B2C3D4, 4'h0);
    burst(WR_CMD, 32'h0000_0010, 4, 4, -1);
    bd_check("wr_0x10", 10'h010, 8'hA1);
    bd_check("wr_0x11", 10'h011, 8'hB2);
    bd_check("wr_0x12", 10'h012, 8'hC3);
    bd_check("wr_0x13", 10'h013, 8'hD4);
    bd_check("ce_wins_0x14", 10'h014, 8'h5A);
    check("wr_err", 32'(err), 32'h0);

    // Read back; the compare process checks each data edge.
    burst(RD_CMD, 32'h0000_0010, 4, 4, -1);
    check("rd_last_io_out", 32'(io_out), 32'hD4);
    check("rd_last_dqs_out", 32'(dqs_out), 32'h1);
    check("rd_err", 32'(err), 32'h0);

    // Wrap-around and odd start address.
    set_wd(32'h01020304, 4'h0);
    burst(WR_CMD, 32'(DEPTH - 2), 4, 4, -1);
    bd_check("wrap_1022", 10'd1022, 8'h01);
    bd_check("wrap_1023", 10'd1023, 8'h02);
    bd_check("wrap_0", 10'd0, 8'h03);
    bd_check("wrap_1", 10'd1, 8'h04);
    set_wd(32'h77880000, 4'h0);
    burst(WR_CMD, 32'h0000_0021, 2, 4, -1);
    bd_check("odd_0x20", 10'h020, 8'h77);
    bd_check("odd_0x21", 10'h021, 8'h88);
    burst(RD_CMD, 32'(DEPTH - 2), 4, 4, -1);

    // Unknown opcode: no write, no output enable, sticky error.
    set_wd(32'h99999999, 4'h0);
    burst(8'h55, 32'h0000_0010, 4, 4, -1);
    check("badop_err", 32'(err), 32'h1);
    bd_check("badop_0x10", 10'h010, 8'hA1);
    set_wd(32'h3C4D0000, 4'h0);
    burst(WR_CMD, 32'h0000_0030, 2, 4, -1);
    check("badop_err_sticky", 32'(err), 32'h1);
    bd_check("after_badop_0x30", 10'h030, 8'h3C);

    // Address abort after two address bytes.
    do_reset();
    check("rst_clears_err", 32'(err), 32'h0);
    burst(WR_CMD, 32'h0000_0010, 4, 2, -1);
    check("abort_err", 32'(err), 32'h1);
    check("abort_busy", 32'(busy), 32'h0);
    bd_check("abort_0x10", 10'h010, 8'hA1);

    // Reset in the middle of a read burst.
    do_reset();
    burst(RD_CMD, 32'h0000_0010, 4, 4, 3);
    check("post_rst_err", 32'(err), 32'h0);

    // Data mask.
    set_wd(32'hF0F1F2F3, 4'h0);
    burst(WR_CMD, 32'h0000_0040, 4, 4, -1);
    set_wd(32'h11223344, 4'b0100);
    burst(WR_CMD, 32'h0000_0040, 4, 4, -1);
    bd_check("dm_0x40", 10'h040, 8'h11);
`ifdef PSRAM_RESP_DM_EN
    bd_check("dm_0x41", 10'h041, 8'hF1);
`else
    bd_check("dm_0x41", 10'h041, 8'h22);
`endif
    bd_check("dm_0x42", 10'h042, 8'h33);
    bd_check("dm_0x43", 10'h043, 8'h44);
    burst(RD_CMD, 32'h0000_0040, 4, 4, -1);

    wait_clk(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/psram_opi_resp.md
Name: psram_opi_resp

Overview:
- Synthesizable OPI PSRAM responder: the device-side end of the PSRAM controller's octal DDR interface.
- Decodes CE/SCK/IO command, address and latency phases, stores write bytes and returns read bytes with a DQS strobe from an internal byte array.
- Used as the loopback target in the PSRAM subsystem bench and as an FPGA stand-in for a real part.
- Oversamples SCK with the system clock; the controller prescaler is at least div4, so every SCK phase spans at least 2 clk_i cycles.

Parameters:
- DEPTH, 1024, byte array size; power of two.
- RD_CMD, 8'h00, linear burst read opcode.
- WR_CMD, 8'h80, linear burst write opcode.
- RLC, 5, read latency in SCK rising edges after the address; must be ≥1.
- WLC, 5, write latency in SCK rising edges after the address; must be ≥1.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- psram_sck_i  in  1  SCK from controller
- psram_ce_i  in  1  chip enable, active low
- psram_io_in_i  in  8  IO driven by controller
- psram_io_out_o  out  8  read data to controller
- psram_io_en_o  out  8  IO output enable, all bits equal
- psram_dqs_in_i  in  1  write data mask from controller
- psram_dqs_out_o  out  1  read strobe
- psram_dqs_en_o  out  1  DQS output enable
- bd_addr_i  in  $clog2(DEPTH)  backdoor read address
- bd_data_o  out  8  backdoor read data, combinational
- busy_o  out  1  high when FSM is not IDLE
- err_o  out  1  sticky; set on unknown opcode or on CE deassert before the address completes; cleared only by reset

Behaviour:
- Clock and reset:
  - Single clock, clk_i; reset rst_n_i is asynchronous and active-low.
  - Reset drives all outputs and state to 0, and the FSM to IDLE. Array contents are not reset.
  - Reset mid-burst aborts the burst. io_en and dqs_en are low in the same cycle reset asserts.
- Input sampling:
  - sck, ce and io pass through identical 2-flop synchronizers.
  - rise = sck_s & ~sck_q; fall = ~sck_s & sck_q. "Edge" means rise or fall.
  - All phase decisions use the synchronized signals.
- FSM states and transitions:
  - IDLE → INST on ce_s falling.
  - INST: capture opcode on the first rise; ignore the fall byte.
    - Opcode matches RD_CMD or WR_CMD: go to ADDR.
    - Otherwise: go to IGNR and set err_o.
  - ADDR: capture 4 bytes on 4 consecutive edges, MSB first.
    - addr = low $clog2(DEPTH) bits, with bit 0 forced to 0 (even start).
    - Then go to LATN with cnt = RLC or WLC.
  - LATN: decrement cnt on each rise.
    - On the rise where cnt reaches 0, go to RDATA or WDATA.
    - The first data edge is the fall that immediately follows that rise.
  - WDATA:
    - Each edge writes io_s to mem[addr], unless the mask is set.
    - addr increments modulo DEPTH (wraps DEPTH-1 → 0).
  - RDATA:
    - Each edge registers io_out = mem[addr] and dqs_out = sck_s; addr increments modulo DEPTH.
    - Output latency is 1 clk after the detected edge, i.e. 3 clk after the pin edge.
    - Asserts io_en = 8'hFF and dqs_en = 1 from LATN exit until CE rises.
  - IGNR: waits for CE high.
- CE rise in any state → IDLE next cycle.
  - io_en and dqs_en drop in the same cycle as the transition.
  - Bytes already written stay committed; an odd byte count is accepted.
- CE rise during INST or ADDR sets err_o.
- Simultaneous CE rise and SCK edge: CE wins; that edge's byte is discarded.
- Backdoor read is asynchronous from the array. A same-cycle write to the same address shows the old value.

Optional Feature:
- Macro PSRAM_RESP_DM_EN.
- Defined: in WDATA, a byte is not written when dqs_s = 1 (data mask); addr still increments.
- Undefined: psram_dqs_in_i is ignored and every WDATA byte is written.

Test Plan:
- Write burst, div4 SCK: WR_CMD, addr 0x00000010, WLC = 5, bytes A1 B2 C3 D4 → bd reads 0x10..0x13 = A1 B2 C3 D4; err_o = 0.
- Read back the same 4 bytes: RD_CMD, addr 0x10 → io_out presents A1 B2 C3 D4 on consecutive edges; dqs toggles 4 times; io_en = FF only during data; busy_o falls 1 clk after CE rise.
- Wrap-around: write 4 bytes at addr DEPTH-2 → bytes land at 1022, 1023, 0, 1; odd addr 0x21 is treated as 0x20.
- Bad opcode 8'h55 → no array change, no output enable, err_o = 1 and stays set across further valid bursts.
- Abort and reset: CE rise after 2 of 4 address bytes → err_o = 1, FSM back in IDLE. rst_n_i low mid-read → io_en, dqs_en, dqs_out, busy_o = 0 immediately.
- PSRAM_RESP_DM_EN defined: write 11 22 33 44 with DQS high on byte 2 → mem = 11, old value, 33, 44. Undefined → 11 22 33 44.
